// File: rtl/mem_pkg.sv
// Shared memory-port types and the arbiter's default sizing.
package mem_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } mem_h2d_t;

  typedef struct packed {
    logic        gnt;
    logic        valid;
    logic [31:0] data;
    logic        error;
  } mem_d2h_t;

  localparam int MEM_ARB_N         = 2;
  localparam int MEM_ARB_IDW       = (MEM_ARB_N > 1) ? $clog2(MEM_ARB_N) : 1;
  localparam int MEM_ARB_MAX_OUTST = 4;

  typedef logic [MEM_ARB_IDW-1:0] mem_arb_id_t;

endpackage

// File: rtl/mem_rsp_fifo.sv
// In-order FIFO of requester IDs, one entry per grant still waiting for its response.
module mem_rsp_fifo #(
  parameter int W     = 1,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic [W-1:0]  head
);

  logic [W-1:0]  slots [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = slots[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload needs no reset: occupancy alone decides what is readable.
  always_ff @(posedge clk) begin
    if (do_push) slots[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one SRAM-style port between N requesters, routing
// in-order responses back through a FIFO of granted requester IDs.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int N        = MEM_ARB_N,
  parameter int MaxOutst = MEM_ARB_MAX_OUTST,
  localparam int IDW     = (N > 1) ? $clog2(N) : 1,
  localparam int CW      = $clog2(MaxOutst + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  mem_h2d_t      req_i [N],
  output mem_d2h_t      rsp_o [N],
  output mem_h2d_t      mem_o,
  input  mem_d2h_t      mem_i,
  output logic [CW-1:0] outst_o,
  output logic          rsp_err_o
);

  // Handshake: a command transfers on the cycle mem_o.req & mem_i.gnt; the
  // requester holds its fields until it sees gnt. Responses carry no ready:
  // each mem_i.valid is consumed the cycle it arrives by the oldest grant.

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] idx;
  logic [IDW-1:0] head;
  logic           any_req;
  logic           accept;
  logic           pop;
  logic           fifo_full;
  logic           fifo_empty;

  // Scan downward so the lowest offset from ptr is assigned last and wins.
  always_comb begin
    any_req = 1'b0;
    winner  = '0;
    idx     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = IDW'((int'(ptr) + k) % N);
      if (req_i[idx].req) begin
        any_req = 1'b1;
        winner  = idx;
      end
    end
  end

  always_comb begin
    mem_o = '0;
    if (!rst_i && any_req && !fifo_full) mem_o = req_i[winner];
  end

  assign accept    = mem_o.req & mem_i.gnt;
  assign pop       = mem_i.valid & ~fifo_empty & ~rst_i;
  assign rsp_err_o = mem_i.valid & fifo_empty & ~rst_i;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      rsp_o[i]     = '0;
      rsp_o[i].gnt = accept && (winner == IDW'(i));
      if (pop && (head == IDW'(i))) begin
        rsp_o[i].valid = 1'b1;
        rsp_o[i].data  = mem_i.data;
        rsp_o[i].error = mem_i.error;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)       ptr <= '0;
    else if (accept) ptr <= (winner == IDW'(N - 1)) ? '0 : winner + 1'b1;
  end

  mem_rsp_fifo #(
    .W    (IDW),
    .DEPTH(MaxOutst)
  ) u_rsp_fifo (
    .clk  (clk_i),
    .rst  (rst_i),
    .push (accept),
    .wdata(winner),
    .pop  (pop),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(outst_o),
    .head (head)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand-written corner sequences,
// and a randomized run against a queue-based reference model.
module tb_mem_arbiter;
  import mem_pkg::*;

  localparam int N    = 2;
  localparam int MAXO = 4;
  localparam int IDW  = 1;

  logic     clk = 1'b0;
  logic     rst = 1'b1;
  mem_h2d_t req [N];
  mem_d2h_t rsp [N];
  mem_h2d_t mem_o_s;
  mem_d2h_t mem_i_s;
  logic [2:0] outst;
  logic     rsp_err;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.N(N), .MaxOutst(MAXO)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    (req),
    .rsp_o    (rsp),
    .mem_o    (mem_o_s),
    .mem_i    (mem_i_s),
    .outst_o  (outst),
    .rsp_err_o(rsp_err)
  );

  typedef struct {
    bit          r0, r1, mg, mv, me;
    logic [31:0] md;
    bit          eg0, eg1, ev0, ev1, espur;
    int          ewin;
    int          eoutst;
  } vec_t;

  vec_t vecs [15];

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit r0, input bit r1, input bit mg, input bit mv,
                        input logic [31:0] md, input bit me);
    req[0]  = '{r0, 1'b0, 32'h10, 32'h0, 4'hf};
    req[1]  = '{r1, 1'b0, 32'h20, 32'h0, 4'hf};
    mem_i_s = '{mg, mv, md, me};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(0, 0, 0, 0, 32'h0, 0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input bit eg0, input bit eg1,
                            input bit ev0, input bit ev1, input logic [31:0] edata,
                            input bit eerr, input bit espur, input mem_h2d_t emem,
                            input int eoutst);
    chk({tag, ".gnt0"},   128'(rsp[0].gnt), 128'(eg0));
    chk({tag, ".gnt1"},   128'(rsp[1].gnt), 128'(eg1));
    chk({tag, ".valid0"}, 128'(rsp[0].valid), 128'(ev0));
    chk({tag, ".valid1"}, 128'(rsp[1].valid), 128'(ev1));
    chk({tag, ".data0"},  128'(rsp[0].data), 128'(ev0 ? edata : 32'h0));
    chk({tag, ".data1"},  128'(rsp[1].data), 128'(ev1 ? edata : 32'h0));
    chk({tag, ".err0"},   128'(rsp[0].error), 128'(ev0 ? eerr : 1'b0));
    chk({tag, ".err1"},   128'(rsp[1].error), 128'(ev1 ? eerr : 1'b0));
    chk({tag, ".rsp_err"}, 128'(rsp_err), 128'(espur));
    chk({tag, ".mem_o"},  128'(mem_o_s), 128'(emem));
    chk({tag, ".outst"},  128'(outst), 128'(eoutst));
  endtask

  // ---------------- reference model state ----------------
  logic [IDW-1:0] exp_q [$];
  int             mptr;
  mem_h2d_t       cur [N];
  bit             granted_prev [N];

  initial begin
    mem_h2d_t emem;
    set_in(1, 1, 1, 1, 32'h1234, 0);
    rst = 1'b1;
    tick();
    check_outs("in_reset", 0, 0, 0, 0, 32'h0, 0, 0, '0, 0);
    tick();
    rst = 1'b0;
    set_in(0, 0, 0, 0, 32'h0, 0);
    #1;
    check_outs("post_reset", 0, 0, 0, 0, 32'h0, 0, 0, '0, 0);
    tick();

    // r0 r1 mg mv me md | eg0 eg1 ev0 ev1 spur win outst
    vecs[0]  = '{1,0,1,0,0,32'h0,        1,0,0,0,0,  0,0}; // single read grant
    vecs[1]  = '{0,0,0,1,0,32'hDEADBEEF, 0,0,1,0,0, -1,1}; // its response
    vecs[2]  = '{0,0,0,1,0,32'h5,        0,0,0,0,1, -1,0}; // spurious valid
    vecs[3]  = '{0,1,1,0,0,32'h0,        0,1,0,0,0,  1,0};
    vecs[4]  = '{1,1,1,1,1,32'hA1,       1,0,0,1,0,  0,1}; // contention starts at 0
    vecs[5]  = '{1,1,1,1,0,32'hA2,       0,1,1,0,0,  1,1};
    vecs[6]  = '{1,1,1,1,0,32'hA3,       1,0,0,1,0,  0,1};
    vecs[7]  = '{1,1,1,1,0,32'hA4,       0,1,1,0,0,  1,1};
    vecs[8]  = '{0,0,0,1,0,32'hA5,       0,0,0,1,0, -1,1};
    vecs[9]  = '{0,0,0,0,0,32'h0,        0,0,0,0,0, -1,0};
    vecs[10] = '{1,0,0,0,0,32'h0,        0,0,0,0,0,  0,0}; // request without gnt
    vecs[11] = '{1,1,0,0,0,32'h0,        0,0,0,0,0,  0,0}; // ptr must hold at 0
    vecs[12] = '{0,1,1,0,0,32'h0,        0,1,0,0,0,  1,0};
    vecs[13] = '{0,0,0,1,0,32'hB0B0,     0,0,0,1,0, -1,1};
    vecs[14] = '{0,0,0,0,0,32'h0,        0,0,0,0,0, -1,0};

    for (int i = 0; i < 15; i++) begin
      set_in(vecs[i].r0, vecs[i].r1, vecs[i].mg, vecs[i].mv, vecs[i].md, vecs[i].me);
      #1;
      emem = (vecs[i].ewin < 0) ? '0 : req[vecs[i].ewin];
      check_outs($sformatf("vec%0d", i), vecs[i].eg0, vecs[i].eg1, vecs[i].ev0,
                 vecs[i].ev1, vecs[i].md, vecs[i].me, vecs[i].espur, emem, vecs[i].eoutst);
      tick();
    end

    // Back-pressure: four grants fill the ID FIFO, then no grant even with a pop.
    do_reset();
    for (int c = 0; c < 4; c++) begin
      set_in(1, 1, 1, 0, 32'h0, 0);
      #1;
      check_outs($sformatf("bp_grant%0d", c), (c % 2) == 0, (c % 2) == 1, 0, 0,
                 32'h0, 0, 0, req[c % 2], c);
      tick();
    end
    set_in(1, 1, 1, 0, 32'h0, 0);
    #1;
    check_outs("bp_full", 0, 0, 0, 0, 32'h0, 0, 0, '0, 4);
    tick();
    set_in(1, 1, 1, 1, 32'hC0FFEE00, 0);
    #1;
    check_outs("bp_pop_no_bypass", 0, 0, 1, 0, 32'hC0FFEE00, 0, 0, '0, 4);
    tick();
    set_in(1, 1, 1, 0, 32'h0, 0);
    #1;
    check_outs("bp_regrant", 1, 0, 0, 0, 32'h0, 0, 0, req[0], 3);
    tick();

    // Write passthrough and ack routing.
    do_reset();
    req[0]  = '0;
    req[1]  = '{1'b1, 1'b1, 32'h40, 32'h12345678, 4'b0011};
    mem_i_s = '{1'b1, 1'b0, 32'h0, 1'b0};
    #1;
    check_outs("wr_cmd", 0, 1, 0, 0, 32'h0, 0, 0, req[1], 0);
    tick();
    req[1]  = '0;
    mem_i_s = '{1'b0, 1'b1, 32'h0, 1'b0};
    #1;
    check_outs("wr_ack", 0, 0, 0, 1, 32'h0, 0, 0, '0, 1);
    tick();

    // Reset with grants outstanding and ptr away from 0.
    do_reset();
    for (int c = 0; c < 3; c++) begin
      set_in(1, 1, 1, 0, 32'h0, 0);
      tick();
    end
    rst = 1'b1;
    set_in(0, 0, 0, 0, 32'h0, 0);
    tick();
    rst = 1'b0;
    set_in(1, 1, 1, 1, 32'h77, 0);
    #1;
    check_outs("rst_flush", 1, 0, 0, 0, 32'h0, 0, 1, req[0], 0);
    tick();

    // Randomized run against the queue model.
    do_reset();
    exp_q.delete();
    mptr = 0;
    for (int i = 0; i < N; i++) begin
      cur[i]          = '0;
      granted_prev[i] = 1'b0;
    end
    for (int cyc = 0; cyc < 1500; cyc++) begin
      int  win;
      bit  ereq, mg, mv, me, espur;
      bit  eg [N];
      bit  ev [N];
      logic [31:0] md;
      for (int i = 0; i < N; i++) begin
        if (!cur[i].req || granted_prev[i]) begin
          cur[i].req  = ($urandom_range(0, 3) != 0);
          cur[i].we   = 1'($urandom_range(0, 1));
          cur[i].addr = $urandom;
          cur[i].data = $urandom;
          cur[i].mask = 4'($urandom_range(0, 15));
        end
        req[i] = cur[i];
      end
      mg = ($urandom_range(0, 3) != 0);
      mv = (exp_q.size() > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 29) == 0);
      md = $urandom;
      me = ($urandom_range(0, 7) == 0);
      mem_i_s = '{mg, mv, md, me};
      #1;

      win = -1;
      for (int k = 0; k < N; k++)
        if (win < 0 && cur[(mptr + k) % N].req) win = (mptr + k) % N;
      ereq  = (win >= 0) && (exp_q.size() < MAXO);
      espur = mv && (exp_q.size() == 0);
      for (int i = 0; i < N; i++) begin
        eg[i] = ereq && mg && (win == i);
        ev[i] = mv && (exp_q.size() > 0) && (exp_q[0] == i);
      end
      emem = ereq ? cur[win] : '0;
      check_outs($sformatf("rnd%0d", cyc), eg[0], eg[1], ev[0], ev[1], md, me, espur,
                 emem, exp_q.size());

      if (mv && exp_q.size() > 0) void'(exp_q.pop_front());
      if (ereq && mg) begin
        exp_q.push_back(IDW'(win));
        mptr = (win + 1) % N;
      end
      for (int i = 0; i < N; i++) granted_prev[i] = eg[i];
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
